calc_sequencer: RTL

- Top-level controller of the calculator. Debounces the key and operation buttons, captures operands A and B from the switches, and latches the operator.
- Sequences the ALU through a start/done handshake, with a timeout.
- Drives the 7-segment display driver's data and control-code inputs. Display codes: 0 plain, 1 negative, 2 error "E000", 4 division.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/calc_sequencer_btn_debounce.sv | 49 ++++
 rtl/calc_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: ALU ops, display codes, FSM states.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam logic [2:0] CODE_PLAIN = 3'd0;
  localparam logic [2:0] CODE_NEG   = 3'd1;
  localparam logic [2:0] CODE_ERR   = 3'd2;
  localparam logic [2:0] CODE_DIV   = 3'd4;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  // Button slots after packing {~arifs, keys}
  localparam int BTN_ENTER = 0;
  localparam int BTN_CLEAR = 1;
  localparam int NUM_BTN   = 6;

  // Lowest-index op button wins when several fire together
  function automatic op_e op_sel(input logic [3:0] p);
    if (p[0]) return OP_ADD;
    if (p[1]) return OP_SUB;
    if (p[2]) return OP_MUL;
    return OP_DIV;
  endfunction

endpackage

// File: rtl/calc_sequencer_btn_debounce.sv
// Single-button debouncer: 2-flop synchronizer, stability counter, level and press pulse.
// Input is active-high; the released level is 0.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          w_diff;
  logic          w_done;

  assign w_diff  = r_sync[1] ^ r_level;
  assign w_done  = (r_cnt == CW'(DEB_CYCLES - 1));
  assign o_level = r_level;
  assign o_press = r_press;

  // Level flips only after DEB_CYCLES consecutive samples that disagree with it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_press <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_press <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator top controller: debounced buttons, operand/op capture, ALU start/done
// handshake with timeout, and registered display data/code.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int TIMEOUT    = 1024,
  parameter int W          = 8
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [W-1:0] sw,
  input  logic [1:0]   keys,
  input  logic [3:0]   arifs,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  output logic         alu_start,
  input  logic         alu_done,
  input  logic [W-1:0] alu_result,
  input  logic [2:0]   alu_code,
  output logic [W-1:0] ind_data,
  output logic [2:0]   ind_code,
  output logic         busy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_press;
  // Debounced levels are only kept for observability; the FSM uses press pulses
  logic [NUM_BTN-1:0] w_unused_level;

  // op buttons are active-low on the pins; invert so every debouncer idles at 0
  assign w_raw = {~arifs, keys};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .i_clk   (Clk),
      .i_rst_n (Rst_n),
      .i_raw   (w_raw[g]),
      .o_level (w_unused_level[g]),
      .o_press (w_press[g])
    );
  end

  logic w_clr, w_ent, w_opev;
  op_e  w_opsel;

  assign w_clr   = w_press[BTN_CLEAR];
  assign w_ent   = w_press[BTN_ENTER] & ~w_clr;
  assign w_opev  = (|w_press[5:2]) & ~w_press[BTN_CLEAR] & ~w_press[BTN_ENTER];
  assign w_opsel = op_sel(w_press[5:2]);

  state_e        r_state, w_state;
  logic [W-1:0]  r_a, w_a, r_b, w_b, r_data, w_data;
  op_e           r_op, w_op;
  logic [2:0]    r_code, w_code;
  logic          r_start, w_start, r_busy, w_busy;
  logic [TW-1:0] r_cnt, w_cnt;

  // Next-state and next-output decode; display follows the destination state
  always_comb begin
    w_state = r_state;
    w_a     = r_a;
    w_b     = r_b;
    w_op    = r_op;
    w_data  = r_data;
    w_code  = r_code;
    w_cnt   = r_cnt;
    case (r_state)
      S_A: begin
        if (w_ent) begin
          w_a     = sw;
          w_state = S_OP;
        end else if (w_opev) begin
          w_a     = sw;
          w_op    = w_opsel;
          w_state = S_B;
        end
      end
      S_OP: begin
        if (w_opev) begin
          w_op    = w_opsel;
          w_state = S_B;
        end
      end
      S_B: begin
        if (w_opev) begin
          w_op = w_opsel;
        end else if (w_ent) begin
          w_b     = sw;
          w_cnt   = '0;
          w_state = S_EXEC;
        end
      end
      S_EXEC: begin
        // A done arriving on the last allowed cycle still wins over the timeout
        if (alu_done) begin
          w_data  = alu_result;
          w_code  = alu_code;
          w_state = S_SHOW;
        end else if (r_cnt == TW'(TIMEOUT - 1)) begin
          w_data  = '0;
          w_code  = CODE_ERR;
          w_state = S_SHOW;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_SHOW: begin
        if (w_ent) begin
          if (r_code == CODE_PLAIN) begin
            w_a     = r_data;
            w_state = S_OP;
          end else begin
            w_a     = '0;
            w_state = S_A;
          end
        end else if (w_opev && (r_code == CODE_PLAIN)) begin
          w_a     = r_data;
          w_op    = w_opsel;
          w_state = S_B;
        end
      end
      default: w_state = S_A;
    endcase

    if (w_clr) begin
      w_state = S_A;
      w_a     = '0;
      w_b     = '0;
      w_op    = OP_ADD;
      w_code  = CODE_PLAIN;
    end

    case (w_state)
      S_A, S_B: begin
        w_data = sw;
        w_code = CODE_PLAIN;
      end
      S_OP: begin
        w_data = w_a;
        w_code = CODE_PLAIN;
      end
      default: ;
    endcase

    w_busy  = (w_state == S_EXEC);
    w_start = (w_state == S_EXEC) && (r_state != S_EXEC);
  end

  // State and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
      r_data  <= '0;
      r_code  <= CODE_PLAIN;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_a     <= w_a;
      r_b     <= w_b;
      r_op    <= w_op;
      r_data  <= w_data;
      r_code  <= w_code;
      r_start <= w_start;
      r_busy  <= w_busy;
      r_cnt   <= w_cnt;
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign alu_start = r_start;
  assign ind_data  = r_data;
  assign ind_code  = r_code;
  assign busy      = r_busy;

endmodule
